// File: rtl/seq_normalizer.sv
// seq_normalizer: left-normalizes a 16-bit operand and reports the shift count and a zero flag.
// Optional macro NORM_FAST_EN: SCAN may shift 4, 2 or 1 bits per cycle instead of exactly 1.
module seq_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] In,
  output logic        busy,
  output logic        done,
  output logic [15:0] Out,
  output logic [3:0]  Cnt,
  output logic        zero
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [15:0] r_work;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_out;
  logic [3:0]  r_cnt_out;
  logic        r_zero;

  logic        w_scan_end;
  logic [1:0]  w_state_nxt;
  logic [15:0] w_work_nxt;
  logic [3:0]  w_cnt_nxt;
  logic [15:0] w_work_shift;
  logic [3:0]  w_cnt_shift;

  assign w_scan_end = r_work[15] || (r_work == 16'h0000);

`ifdef NORM_FAST_EN
  // Widest shift that cannot push a set bit past bit 15
  always_comb begin
    w_work_shift = {r_work[14:0], 1'b0};
    w_cnt_shift  = r_cnt + 4'd1;
    if ((r_work[15:12] == 4'b0000) && (r_work != 16'h0000)) begin
      w_work_shift = {r_work[11:0], 4'b0000};
      w_cnt_shift  = r_cnt + 4'd4;
    end else if (r_work[15:14] == 2'b00) begin
      w_work_shift = {r_work[13:0], 2'b00};
      w_cnt_shift  = r_cnt + 4'd2;
    end else begin
      w_work_shift = {r_work[14:0], 1'b0};
      w_cnt_shift  = r_cnt + 4'd1;
    end
  end
`else
  assign w_work_shift = {r_work[14:0], 1'b0};
  assign w_cnt_shift  = r_cnt + 4'd1;
`endif

  // Next-state logic; start is only honoured outside SCAN
  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_SCAN;
          w_work_nxt  = In;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (w_scan_end) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_work_nxt = w_work_shift;
          w_cnt_nxt  = w_cnt_shift;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_work_nxt  = 16'h0000;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State, datapath and registered outputs; results only change on DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_work    <= 16'h0000;
      r_cnt     <= 4'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_out     <= 16'h0000;
      r_cnt_out <= 4'd0;
      r_zero    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == ST_SCAN);
      r_done  <= (w_state_nxt == ST_DONE);
      if ((r_state == ST_SCAN) && w_scan_end) begin
        r_out     <= r_work;
        r_cnt_out <= r_cnt;
        r_zero    <= (r_work == 16'h0000);
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Out  = r_out;
  assign Cnt  = r_cnt_out;
  assign zero = r_zero;

endmodule

// File: tb/tb_seq_normalizer.sv
// Self-checking bench for seq_normalizer: directed corner cases plus randomized operands
// compared against a leading-zero-count reference model.
module tb_seq_normalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] In;
  logic        busy;
  logic        done;
  logic [15:0] Out;
  logic [3:0]  Cnt;
  logic        zero;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] last_out;
  logic [3:0]  last_cnt;
  logic        last_zero;

  seq_normalizer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .In    (In),
    .busy  (busy),
    .done  (done),
    .Out   (Out),
    .Cnt   (Cnt),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Result = operand shifted by its leading-zero count; latency = number of shift cycles
  function automatic void ref_model(input logic [15:0] v, output logic [15:0] o,
                                    output logic [3:0] c, output logic z, output int lat);
    int k;
    k = 0;
    if (v != 16'h0000) begin
      while (k < 15 && v[15-k] == 1'b0) k++;
    end
    o = v << k;
    c = 4'(k);
    z = (v == 16'h0000);
`ifdef NORM_FAST_EN
    lat = k / 4 + (k % 4) / 2 + k % 2;
`else
    lat = k;
`endif
  endfunction

  task automatic drive_noise(input bit noisy);
    start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    In    = 16'($urandom);
  endtask

  task automatic start_op(input logic [15:0] v);
    @(negedge clk);
    start = 1'b1;
    In    = v;
    @(posedge clk);
  endtask

  // Called right after the accepting edge; optionally chains a new start in the DONE cycle
  task automatic finish_op(input logic [15:0] v, input bit noisy, input bit chain,
                           input logic [15:0] nval);
    logic [15:0] eo;
    logic [3:0]  ec;
    logic        ez;
    int          el;
    int          cyc;
    ref_model(v, eo, ec, ez, el);
    cyc = 0;
    @(negedge clk);
    check_val("busy_first", busy, 1);
    check_val("done_first", done, 0);
    check_val("out_held", Out, last_out);
    check_val("cnt_held", Cnt, last_cnt);
    check_val("zero_held", zero, last_zero);
    drive_noise(noisy);
    while (1) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) break;
      check_val("busy_scan", busy, 1);
      if (cyc > 40) begin
        check_val("timeout", cyc, el + 1);
        break;
      end
      drive_noise(noisy);
    end
    check_val("latency", cyc, el + 1);
    check_val("out", Out, eo);
    check_val("cnt", Cnt, ec);
    check_val("zero", zero, ez);
    check_val("busy_done", busy, 0);
    last_out  = eo;
    last_cnt  = ec;
    last_zero = ez;
    if (chain) begin
      start = 1'b1;
      In    = nval;
      @(posedge clk);
    end else begin
      start = 1'b0;
      In    = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_val("done_pulse_len", done, 0);
      check_val("busy_idle", busy, 0);
      check_val("out_after", Out, eo);
    end
  endtask

  initial begin
    logic [15:0] dir_vals [6];
    logic [15:0] v;
    bit          saw_done;

    dir_vals = '{16'h8000, 16'h0001, 16'h0000, 16'hFFFF, 16'h4000, 16'h0300};
    start = 1'b0;
    In    = 16'h0000;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_out", Out, 0);
    check_val("rst_cnt", Cnt, 0);
    check_val("rst_zero", zero, 0);
    last_out  = 16'h0000;
    last_cnt  = 4'd0;
    last_zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (dir_vals[i]) begin
      start_op(dir_vals[i]);
      finish_op(dir_vals[i], 1'b0, 1'b0, 16'h0000);
    end

    // Back-to-back: new start in the DONE cycle
    start_op(16'h0300);
    finish_op(16'h0300, 1'b0, 1'b1, 16'h4000);
    finish_op(16'h4000, 1'b0, 1'b0, 16'h0000);

    for (int n = 0; n < 150; n++) begin
      v = 16'($urandom) >> $urandom_range(0, 16);
      start_op(v);
      finish_op(v, 1'b1, 1'b0, 16'h0000);
    end

    // Reset mid-SCAN with an ignored second start
    start_op(16'h0300);
    @(negedge clk);
    start = 1'b1;
    In    = 16'hFFFF;
    check_val("abort_busy1", busy, 1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_val("abort_busy2", busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    check_val("abort_out", Out, 0);
    check_val("abort_cnt", Cnt, 0);
    check_val("abort_zero", zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_out  = 16'h0000;
    last_cnt  = 4'd0;
    last_zero = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check_val("no_done_after_rst", saw_done, 0);
    check_val("out_after_rst", Out, 0);

    // Start presented at the very first edge after reset release
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    In    = 16'h0300;
    @(posedge clk);
    finish_op(16'h0300, 1'b0, 1'b0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_normalizer.md
SEQ_NORMALIZER -- requirements
Module: seq_normalizer

Interface
REQ-001 SHALL have ports: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have: start  input  1  request; sampled on rising clk only while busy=0.
REQ-004 SHALL have: In  input  16  operand captured on the accepted start.
REQ-005 SHALL have: busy  output  1  high while a normalization is in progress.
REQ-006 SHALL have: done  output  1  one-cycle pulse; result valid.
REQ-007 SHALL have: Out  output  16  normalized value, i.e. In shifted left until bit15=1.
REQ-008 SHALL have: Cnt  output  4  left-shift count applied; feeding it to a left shift of In reproduces Out.
REQ-009 SHALL have: zero  output  1  high when the captured operand was 0x0000.

Function
REQ-010 SHALL implement FSM states IDLE, SCAN, DONE; busy=1 only in SCAN.
REQ-011 IDLE/DONE with start=1 at an edge SHALL load the work register with In, clear the count, and enter SCAN.
REQ-012 DONE with start=0 SHALL return to IDLE; done=1 only in DONE (exactly one cycle).
REQ-013 SCAN SHALL go to DONE when work[15]=1 or work=0x0000; otherwise it SHALL shift work left 1 bit with zero fill and increment the count.
REQ-014 On entering DONE, Out, Cnt and zero SHALL be registered from the work register and count; they SHALL hold until the next accepted start loads new values at DONE entry.
REQ-015 Operand 0x0000 SHALL give Out=0x0000, Cnt=0, zero=1; any nonzero operand SHALL give zero=0.
REQ-016 Count SHALL never exceed 15; shifts SHALL never wrap bits from the MSB back in (logical, not rotate).
REQ-017 Latency (base build): start-accept edge E0; k = required shifts; done high in the cycle after edge E0+k+1.
REQ-018 start while busy=1 SHALL be ignored with no effect on the operation in progress.
REQ-019 In SHALL be sampled only at the accepting edge; changes during SCAN SHALL not affect the result.

Reset
REQ-020 rst_n=0 SHALL immediately, without clk, force state=IDLE, busy=0, done=0, Out=0x0000, Cnt=0, zero=0, and clear the work register and count.
REQ-021 Reset asserted mid-SCAN SHALL abort the operation; no done pulse SHALL follow deassertion.
REQ-022 After rst_n rises, the first start SHALL be acceptable at the first clk edge.

Configuration
REQ-023 Macro NORM_FAST_EN SHALL, when defined, allow multi-bit shifts in SCAN. Per cycle: 4 bits if work[15:12]=0 and work!=0; else 2 bits if work[15:14]=0; else 1 bit if work[15]=0.
REQ-024 With NORM_FAST_EN, Out/Cnt/zero SHALL be identical to the base build; only latency differs (s = number of shift cycles, done after edge E0+s+1).
REQ-025 Without NORM_FAST_EN, the SCAN state SHALL shift exactly 1 bit per cycle and no multi-bit logic SHALL be present.

Verification
REQ-026 In=0x8000, start 1 cycle -> done after edge E0+1, Out=0x8000, Cnt=0, zero=0.
REQ-027 In=0x0001 base build -> done after edge E0+16, Out=0x8000, Cnt=15.
REQ-028 In=0x0001 with NORM_FAST_EN -> shifts 4,4,4,2,1; done after edge E0+6, Out=0x8000, Cnt=15.
REQ-029 In=0x0000 -> done after edge E0+1, Out=0x0000, Cnt=0, zero=1.
REQ-030 In=0x0300, second start with In=0xFFFF during SCAN, then rst_n pulse at the 3rd SCAN cycle. Required: second start ignored; after reset all outputs 0 and no done pulse. New start with In=0x0300 -> Out=0xC000, Cnt=6.
REQ-031 Back-to-back: start held high during DONE with In=0x4000 -> new operation accepted and results from REQ-014 held until DONE entry. Next done: Out=0x8000, Cnt=1.
